// File: rtl/rcla15_accum_ctrl.sv
// rcla15_accum_ctrl
// Sequencing stage around an external 15-bit carry look-ahead adder.
// Accepted terms are summed into a running total by steering
// X = running total and Y = term onto the adder and capturing its 16-bit sum.
// When the last term of a packet is accepted, the block presents the total,
// a sticky carry-out flag and a saturating term count on a valid/ready port.
// The block then holds that result until the consumer takes it.

module rcla15_accum_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  // upstream term stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      in_data,
  input  logic             in_last,
  // external combinational adder
  output logic [14:0]      add_x,
  output logic [14:0]      add_y,
  input  logic [15:0]      add_s,
  // packet result
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [14:0]      acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             take;
  logic             cnt_full;

  // Handshake qualifiers.
  // in_ready depends only on the state decode. Because of that, out_ready can never
  // reach in_ready combinationally.
  assign accept   = in_valid & in_ready;
  assign take     = (state == HOLD) & out_ready;
  assign cnt_full = (cnt == {CNT_W{1'b1}});

  // Adder steering: the running total is always on X. Y is zeroed unless a term is
  // actually being accepted, so add_s only ever carries a meaningful sum on accept.
  assign add_x = acc;
  assign add_y = accept ? in_data : 15'd0;

  // The result port reflects the live registers. While in HOLD nothing can update
  // them, so the reported values are stable for as long as the result waits.
  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = cnt;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the state-derived handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would otherwise infer a latch.
    state_nxt = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && in_last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: on accept, capture the adder sum, OR in its carry-out and bump the
  // saturating count. When the result is taken, clear everything so the next
  // packet starts from zero. A reset discards any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 15'd0;
      ovf <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= add_s[14:0];
      ovf <= ovf | add_s[15];
      if (!cnt_full) begin
        cnt <= cnt + 1'b1;
      end
    end else if (take) begin
      acc <= 15'd0;
      ovf <= 1'b0;
      cnt <= '0;
    end
  end

endmodule

// File: doc/rcla15_accum_ctrl.md
# rcla15_accum_ctrl

Sequencing stage that wraps the 15-bit ripple-block carry look-ahead adder to accumulate a packet of operands. Each accepted term is driven onto the adder as X = running total, Y = term, and the adder's 16-bit sum is captured back into the accumulator. On the last term of a packet, the result is presented on a valid/ready output port together with a sticky overflow flag and a term count. The adder itself stays external and combinational; this block owns all state and both handshakes.

## Interface
- CNT_W, default 8: width of the term counter; the count saturates at 2^CNT_W-1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream term valid.
- in_ready  output  1  block can accept a term.
- in_data  input  15  operand term, unsigned.
- in_last  input  1  marks the final term of the packet; qualified by the in handshake.
- add_x  output  15  to adder X input.
- add_y  output  15  to adder Y input.
- add_s  input  16  from adder S output, combinational from add_x/add_y.
- out_valid  output  1  packet result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  15  accumulated total, modulo 2^15.
- out_ovf  output  1  set if any addition in the packet carried out (add_s[15]).
- out_count  output  CNT_W  number of terms in the packet, saturating.

## Operation
- State registers: acc[14:0], ovf, cnt[CNT_W-1:0], and an FSM with states IDLE, ACCUM, HOLD.
- Combinational outputs:
  - add_x = acc in every state.
  - add_y = in_data when in_valid & in_ready, else 0.
  - in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
  - out_valid = 1 only in HOLD.
  - out_sum = acc, out_ovf = ovf, out_count = cnt.
- On accept (in_valid & in_ready):
  - acc <= add_s[14:0].
  - ovf <= ovf | add_s[15].
  - cnt <= cnt+1, held at all-ones once reached.
- Transitions:
  - IDLE→ACCUM on accept with in_last=0.
  - IDLE→HOLD on accept with in_last=1.
  - ACCUM→HOLD on accept with in_last=1.
  - ACCUM stays in ACCUM on accept with in_last=0, and with no accept.
  - HOLD→IDLE on out_ready. In that same edge: acc, ovf and cnt are cleared to 0.
- Once ovf is set in a packet it stays set until the result is taken; acc keeps accumulating the wrapped low 15 bits.
- While in HOLD, no term is accepted; in_data and in_last are ignored.
- Reset (rst_n low, any time, including mid-packet or in HOLD):
  - acc=0, ovf=0, cnt=0, state=IDLE.
  - in_ready=1, out_valid=0, add_x=0.
  - Any partial packet is discarded. Deassertion is synchronised externally.

## Timing
- One term per cycle sustained in IDLE/ACCUM.
- Critical path: in_data → add_y → adder → add_s → acc D-input, all within one cycle.
- Result latency: out_valid rises on the clock edge that accepts the in_last term. out_sum already includes that term.
- out_sum, out_ovf and out_count are stable while out_valid=1 and out_ready=0.
- After the out handshake: one cycle in IDLE with in_ready=1. The earliest next term is accepted on the cycle after HOLD exits, giving one bubble per packet.
- in_valid/in_ready and out_valid/out_ready follow standard rules: the source holds data stable until the handshake completes, and no combinational path runs from out_ready to in_ready within a cycle beyond the state decode.

## Test plan
- Single term: in_data=5, in_last=1 → next cycle out_valid=1, out_sum=5, out_ovf=0, out_count=1; add_x was 0 during accept.
- Three terms, back-to-back: 100, 200, 300 (last) → out_sum=600, out_ovf=0, out_count=3, with in_ready=1 throughout the packet.
- Overflow: 0x7FFF, then 1, then 5 (last) → out_sum=5, out_ovf=1, out_count=3. ovf is captured on the second term and stays set.
- Backpressure: complete the packet {10 last} with out_ready=0 for 4 cycles → out_sum=10 held, in_ready=0, and an in_valid=1 with in_data=99 is ignored. Raise out_ready → IDLE, then the next packet {99 last} yields out_sum=99.
- Reset mid-packet: accept 7 and 8, pulse rst_n low asynchronously → out_valid=0, acc=0, in_ready=1 immediately. Then {4 last} → out_sum=4, out_count=1.
- Count saturation (CNT_W=8): 300 terms of value 1, last on the 300th → out_count=255, out_sum=300, out_ovf=0.
